// File: rtl/accel_pkg.sv
// Shared tilt encoding, parameter defaults and the per-axis tilt next-state rule.
// No storage here: pure types, constants and a combinational helper.
package accel_pkg;

  localparam int DATA_W         = 16;
  localparam int DEF_SAMPLE_DIV = 50000;
  localparam int DEF_AVG_LOG2   = 3;
  localparam int DEF_TILT_TH    = 64;
  localparam int DEF_HYST       = 16;

  typedef enum logic [1:0] {
    TILT_LEVEL = 2'b00,
    TILT_NEG   = 2'b01,
    TILT_POS   = 2'b10
  } tilt_e;

  // Entering a tilt needs the full threshold; leaving to LEVEL uses the
  // threshold reduced by the hysteresis band, and a full swing jumps directly.
  function automatic tilt_e tilt_next(input tilt_e cur, input logic signed [DATA_W-1:0] avg,
                                      input int th, input int hyst);
    tilt_e nxt;
    nxt = cur;
    case (cur)
      TILT_LEVEL: begin
        if (avg >= th)       nxt = TILT_POS;
        else if (avg <= -th) nxt = TILT_NEG;
      end
      TILT_POS: begin
        if (avg <= -th)             nxt = TILT_NEG;
        else if (avg < (th - hyst)) nxt = TILT_LEVEL;
      end
      TILT_NEG: begin
        if (avg >= th)                 nxt = TILT_POS;
        else if (avg > -(th - hyst))   nxt = TILT_LEVEL;
      end
      default: nxt = TILT_LEVEL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/accel_axis_avg.sv
// One-axis moving average over 2^AVG_LOG2 accepted samples (circular buffer + running sum).
// Latency 1 cycle from i_accept to o_avg/o_valid; no backpressure, accepts whenever strobed.
module accel_axis_avg
  import accel_pkg::*;
#(
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_accept,
  input  logic signed [DATA_W-1:0] i_sample,
  output logic signed [DATA_W-1:0] o_avg,
  output logic                     o_valid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2 + 1)'(DEPTH - 1);
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);

  logic signed [DATA_W-1:0] r_buf [DEPTH];
  logic [AVG_LOG2-1:0]      r_idx;
  logic [AVG_LOG2:0]        r_fill;
  logic signed [SUM_W-1:0]  r_sum;

  logic signed [SUM_W-1:0]  w_new;
  logic signed [SUM_W-1:0]  w_old;
  logic signed [SUM_W-1:0]  w_sum_nxt;
  logic signed [DATA_W-1:0] w_avg;

  // Buffer starts zeroed, so during fill the subtracted entry contributes nothing.
  always_comb begin
    w_new     = {{AVG_LOG2{i_sample[DATA_W-1]}}, i_sample};
    w_old     = {{AVG_LOG2{r_buf[r_idx][DATA_W-1]}}, r_buf[r_idx]};
    w_sum_nxt = r_sum + w_new - w_old;
    w_avg     = DATA_W'(w_sum_nxt >>> AVG_LOG2);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_idx   <= '0;
      r_fill  <= '0;
      r_sum   <= '0;
      o_avg   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_accept) begin
        r_buf[r_idx] <= i_sample;
        r_idx        <= r_idx + AVG_LOG2'(1);
        r_sum        <= w_sum_nxt;
        o_avg        <= w_avg;
        o_valid      <= (r_fill >= FILL_LAST);
        if (r_fill != FILL_FULL) r_fill <= r_fill + (AVG_LOG2 + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/accel_filter.sv
// Accelerometer front end: double-flop capture, tick-paced coherent sampling, 3-axis average, tilt FSMs.
// avg_* one cycle after acceptance, tilt_* one cycle after avg_valid; no backpressure.
module accel_filter
  import accel_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int AVG_LOG2   = DEF_AVG_LOG2,
  parameter int TILT_TH    = DEF_TILT_TH,
  parameter int HYST       = DEF_HYST
) (
  input  logic                     clock_50MHz,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_x,
  input  logic signed [DATA_W-1:0] data_y,
  input  logic signed [DATA_W-1:0] data_z,
  output logic signed [DATA_W-1:0] avg_x,
  output logic signed [DATA_W-1:0] avg_y,
  output logic signed [DATA_W-1:0] avg_z,
  output logic                     avg_valid,
  output logic [1:0]               tilt_lr,
  output logic [1:0]               tilt_fb
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);

  logic signed [DATA_W-1:0] r_s1_x, r_s1_y, r_s1_z;
  logic signed [DATA_W-1:0] r_s2_x, r_s2_y, r_s2_z;
  logic [TICK_W-1:0]        r_tick;
  logic                     r_pend;
  tilt_e                    r_lr, r_fb;

  logic  w_coherent;
  logic  w_tick_tc;
  logic  w_accept;
  logic  w_vld_x, w_vld_y, w_vld_z;
  tilt_e w_lr_nxt, w_fb_nxt;

  // The SPI stage is asynchronous: only a cycle where both stages agree on all axes is safe to take.
  assign w_coherent = (r_s1_x == r_s2_x) && (r_s1_y == r_s2_y) && (r_s1_z == r_s2_z);
  assign w_tick_tc  = (r_tick == TICK_LAST);
  assign w_accept   = r_pend && w_coherent;

  always_ff @(posedge clock_50MHz) begin
    if (!reset) begin
      r_s1_x <= '0; r_s1_y <= '0; r_s1_z <= '0;
      r_s2_x <= '0; r_s2_y <= '0; r_s2_z <= '0;
    end else begin
      r_s1_x <= data_x; r_s1_y <= data_y; r_s1_z <= data_z;
      r_s2_x <= r_s1_x; r_s2_y <= r_s1_y; r_s2_z <= r_s1_z;
    end
  end

  // A terminal count wins over the acceptance clear so a coincident tick is never lost.
  always_ff @(posedge clock_50MHz) begin
    if (!reset) begin
      r_tick <= '0;
      r_pend <= 1'b0;
    end else begin
      r_tick <= w_tick_tc ? '0 : r_tick + TICK_W'(1);
      if (w_tick_tc)     r_pend <= 1'b1;
      else if (w_accept) r_pend <= 1'b0;
    end
  end

  accel_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_x (
    .i_clk(clock_50MHz), .i_rst_n(reset), .i_accept(w_accept), .i_sample(r_s2_x),
    .o_avg(avg_x), .o_valid(w_vld_x)
  );

  accel_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_y (
    .i_clk(clock_50MHz), .i_rst_n(reset), .i_accept(w_accept), .i_sample(r_s2_y),
    .o_avg(avg_y), .o_valid(w_vld_y)
  );

  accel_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_z (
    .i_clk(clock_50MHz), .i_rst_n(reset), .i_accept(w_accept), .i_sample(r_s2_z),
    .o_avg(avg_z), .o_valid(w_vld_z)
  );

  assign avg_valid = w_vld_x & w_vld_y & w_vld_z;

  always_comb begin
    w_lr_nxt = r_lr;
    w_fb_nxt = r_fb;
    if (avg_valid) begin
      w_lr_nxt = tilt_next(r_lr, avg_x, TILT_TH, HYST);
      w_fb_nxt = tilt_next(r_fb, avg_y, TILT_TH, HYST);
    end
  end

  always_ff @(posedge clock_50MHz) begin
    if (!reset) begin
      r_lr <= TILT_LEVEL;
      r_fb <= TILT_LEVEL;
    end else begin
      r_lr <= w_lr_nxt;
      r_fb <= w_fb_nxt;
    end
  end

  assign tilt_lr = r_lr;
  assign tilt_fb = r_fb;

endmodule

// File: tb/tb_accel_filter.sv
// Bench for accel_filter with a 10-cycle sample tick: table of held input phases plus toggle/reset sequences,
// averages and tilt states predicted by an independent model and checked from a scoreboard queue.
module tb_accel_filter;

  localparam int SDIV = 10;
  localparam int TH   = 64;
  localparam int HY   = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] dx, dy, dz;
  logic signed [15:0] avg_x, avg_y, avg_z;
  logic               avg_valid;
  logic [1:0]         tilt_lr, tilt_fb;

  always #5 clk = ~clk;

  accel_filter #(.SAMPLE_DIV(SDIV), .AVG_LOG2(3), .TILT_TH(TH), .HYST(HY)) dut (
    .clock_50MHz(clk), .reset(rst_n),
    .data_x(dx), .data_y(dy), .data_z(dz),
    .avg_x(avg_x), .avg_y(avg_y), .avg_z(avg_z),
    .avg_valid(avg_valid), .tilt_lr(tilt_lr), .tilt_fb(tilt_fb)
  );

  typedef struct { int ax; int ay; int az; } exp_t;
  typedef struct { int x; int y; int z; int n; logic [1:0] lr; logic [1:0] fb; } row_t;

  exp_t       sb[$];
  row_t       tbl[8];
  int         hx[8], hy[8], hz[8];
  int         hidx, hcnt;
  int         nchk, nerr, exp_pulses, got_pulses;
  logic [1:0] m_lr, m_fb;
  bit         tchk;

  function automatic int floor8(input int s);
    int r;
    r = s % 8;
    if (r < 0) r += 8;
    return (s - r) / 8;
  endfunction

  function automatic logic [1:0] ref_tilt(input logic [1:0] cur, input int a);
    logic [1:0] n;
    n = cur;
    if (cur == 2'b00) begin
      if (a >= TH) n = 2'b10; else if (a <= -TH) n = 2'b01;
    end else if (cur == 2'b10) begin
      if (a <= -TH) n = 2'b01; else if (a < TH - HY) n = 2'b00;
    end else begin
      if (a >= TH) n = 2'b10; else if (a > -(TH - HY)) n = 2'b00;
    end
    return n;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (rst_n) begin
      if (tchk) begin
        tchk = 1'b0;
        chk("tilt_lr", tilt_lr, m_lr);
        chk("tilt_fb", tilt_fb, m_fb);
      end
      if (avg_valid) begin
        got_pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("avg_x", avg_x, e.ax);
          chk("avg_y", avg_y, e.ay);
          chk("avg_z", avg_z, e.az);
          m_lr = ref_tilt(m_lr, e.ax);
          m_fb = ref_tilt(m_fb, e.ay);
          tchk = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input int x, input int y, input int z);
    int sx, sy, sz;
    hx[hidx] = x; hy[hidx] = y; hz[hidx] = z;
    hidx = (hidx + 1) % 8;
    hcnt++;
    if (hcnt >= 8) begin
      sx = 0; sy = 0; sz = 0;
      for (int i = 0; i < 8; i++) begin
        sx += hx[i]; sy += hy[i]; sz += hz[i];
      end
      sb.push_back('{floor8(sx), floor8(sy), floor8(sz)});
      exp_pulses++;
    end
  endtask

  task automatic put(input int x, input int y, input int z);
    dx = 16'(x); dy = 16'(y); dz = 16'(z);
    push_sample(x, y, z);
    repeat (SDIV) cyc();
  endtask

  // X toggles a/b for ntog cycles then settles on v; nacc is how many samples of v must be taken.
  task automatic put_toggle(input int v, input int a, input int b, input int ntog, input int nwin,
                            input int nacc);
    for (int i = 0; i < nacc; i++) push_sample(v, dy, dz);
    for (int k = 0; k < nwin; k++) begin
      if (k < ntog) dx = 16'(((k % 2) == 0) ? a : b);
      else          dx = 16'(v);
      cyc();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    chk("rst_avg_x", avg_x, 0);
    chk("rst_avg_y", avg_y, 0);
    chk("rst_avg_z", avg_z, 0);
    chk("rst_valid", avg_valid, 0);
    chk("rst_tilt_lr", tilt_lr, 0);
    chk("rst_tilt_fb", tilt_fb, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin hx[i] = 0; hy[i] = 0; hz[i] = 0; end
    hidx = 0; hcnt = 0;
    sb.delete();
    m_lr = 2'b00; m_fb = 2'b00; tchk = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    rst_n = 1'b0; dx = '0; dy = '0; dz = '0;
    nchk = 0; nerr = 0; exp_pulses = 0; got_pulses = 0;
    hidx = 0; hcnt = 0; m_lr = 2'b00; m_fb = 2'b00; tchk = 1'b0;

    tbl[0] = '{80,     -8,     100,    8, 2'b10, 2'b00};
    tbl[1] = '{80,      8,    -100,    8, 2'b10, 2'b00};
    tbl[2] = '{60,      0,       0,    8, 2'b10, 2'b00};
    tbl[3] = '{40,     -1,       0,    1, 2'b10, 2'b00};
    tbl[4] = '{40,      0,       0,    7, 2'b00, 2'b00};
    tbl[5] = '{-70,    70,       5,    8, 2'b01, 2'b10};
    tbl[6] = '{70,    -70,       5,    8, 2'b10, 2'b01};
    tbl[7] = '{-32768, 32767, -32768,  1, 2'b01, 2'b10};

    #1;
    do_reset();

    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < tbl[r].n; s++) put(tbl[r].x, tbl[r].y, tbl[r].z);
      chk("row_pulses", got_pulses, exp_pulses);
      chk("row_tilt_lr", tilt_lr, tbl[r].lr);
      chk("row_tilt_fb", tilt_fb, tbl[r].fb);
    end

    // Settles after the pending tick: one late sample plus the next tick's sample.
    put_toggle(100, 1, 2, 12, 20, 2);
    chk("toggle_pulses", got_pulses, exp_pulses);
    // First coherent cycle lands on a terminal count, so pending re-arms and takes a second sample.
    put_toggle(-100, 1, 2, 14, 20, 2);
    chk("coincide_pulses", got_pulses, exp_pulses);
    // Incoherent across two ticks: the second tick must not queue an extra sample.
    put_toggle(50, 3, 4, 25, 30, 1);
    chk("long_incoh_pulses", got_pulses, exp_pulses);

    do_reset();
    for (int s = 0; s < 7; s++) put(80, -8, 100);
    chk("post_rst_silent", got_pulses, exp_pulses);
    put(80, -8, 100);
    chk("post_rst_first", got_pulses, exp_pulses);
    chk("post_rst_tilt_lr", tilt_lr, 2);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/accel_filter.md
ACCEL_FILTER -- requirements
Module: accel_filter

Interface
REQ-001 Parameter SAMPLE_DIV, default 50000, meaning clock cycles per sample tick (1 kHz at 50 MHz).
REQ-002 Parameter AVG_LOG2, default 3, meaning moving-average depth = 2^AVG_LOG2 samples.
REQ-003 Parameter TILT_TH, default 64, meaning signed magnitude threshold for entering a tilt state.
REQ-004 Parameter HYST, default 16, meaning hysteresis subtracted from TILT_TH for leaving a tilt state.
REQ-005 clock_50MHz  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 data_x / data_y / data_z  in  16 each  signed two's-complement accelerometer samples from the SPI readback stage; asynchronous to clock_50MHz and may change at any cycle.
REQ-008 avg_x / avg_y / avg_z  out  16 each  signed moving average per axis.
REQ-009 avg_valid  out  1  single-cycle pulse when avg_* updated.
REQ-010 tilt_lr  out  2  X-axis tilt: 00 level, 01 negative, 10 positive; 11 never driven.
REQ-011 tilt_fb  out  2  Y-axis tilt, same encoding as tilt_lr.

Function
REQ-012 Each input axis SHALL pass through two register stages (s1, s2); a capture is coherent only in a cycle where s1 == s2 for all three axes.
REQ-013 A tick counter SHALL count 0..SAMPLE_DIV-1 and wrap; terminal count sets a pending flag.
REQ-014 In the first cycle with pending set and coherent true, the s2 values SHALL be accepted and pending cleared; ticks while pending is already set SHALL NOT queue a second sample.
REQ-015 Per axis, a circular buffer of 2^AVG_LOG2 entries SHALL store accepted samples; write index wraps from 2^AVG_LOG2-1 to 0.
REQ-016 Running sum, signed 16+AVG_LOG2 bits, SHALL update as sum + new - overwritten entry; no saturation needed (no overflow possible).
REQ-017 avg_* SHALL equal sum arithmetically shifted right by AVG_LOG2 (rounds toward negative infinity).
REQ-018 avg_* and avg_valid SHALL update in the cycle after acceptance (latency 1).
REQ-019 avg_valid SHALL stay low until 2^AVG_LOG2 samples have been accepted since reset; the acceptance that fills the buffer produces the first pulse.
REQ-020 Tilt FSM per axis (X->tilt_lr, Y->tilt_fb), states LEVEL/NEG/POS, evaluated only when avg_valid is high, output registered (tilt valid 1 cycle after avg_valid).
REQ-021 LEVEL->POS if avg >= TILT_TH; LEVEL->NEG if avg <= -TILT_TH; otherwise stay.
REQ-022 POS->NEG if avg <= -TILT_TH; POS->LEVEL if avg < TILT_TH-HYST; otherwise stay. NEG mirror: NEG->POS if avg >= TILT_TH; NEG->LEVEL if avg > -(TILT_TH-HYST).
REQ-023 Z axis SHALL be averaged but SHALL NOT drive any FSM.
REQ-024 Tick terminal count coinciding with an acceptance cycle SHALL set pending again (acceptance clear loses to new set).

Reset
REQ-025 While reset is low at a clock edge: avg_* = 0, avg_valid = 0, tilt_* = 00, sum, buffers, fill count, indices, tick counter, pending, s1, s2 all cleared.
REQ-026 Reset asserted mid-operation SHALL discard all history; post-reset behaviour is identical to power-up, including the fill requirement of REQ-019.

Structure
REQ-027 Package accel_pkg SHALL hold the tilt encoding constants (LEVEL=00, NEG=01, POS=10) and default parameter values.
REQ-028 Sub-module accel_axis_avg (buffer, sum, shift) SHALL be instantiated three times; tick, sync/coherence and tilt FSMs stay in accel_filter.

Verification (use SAMPLE_DIV=10)
REQ-029 Constant data_x=80 after reset -> avg_valid first pulses after 8th acceptance, avg_x=80, tilt_lr=10 one cycle later.
REQ-030 data_y=-8 then stepped to 8 -> avg_y passes through -8,-6,...,6,8 over eight pulses; -1-style odd sums round down (e.g. sum=-1 gives -1).
REQ-031 X at 80 (POS) then 60 -> tilt_lr stays 10; then 40 long enough for avg <48 -> 00; then -70 -> 01.
REQ-032 data_x toggled every cycle during a tick -> no acceptance until two equal consecutive s1/s2 values; pending holds, no lost or duplicated sample.
REQ-033 reset low for one cycle after 20 acceptances -> all outputs 0/00 next cycle, avg_valid silent for next 7 acceptances.
REQ-034 Tick coincident with acceptance, inputs incoherent for >SAMPLE_DIV cycles -> exactly one sample accepted when coherent.
